p2s_share_ctrl: RTL

- Controller that shares one board serial shift chain (clock, data, clear, latch-enable) between two parallel-data requesters, e.g. the LED port and the 7-segment port.
- Arbitrates round-robin and captures the granted word.
- Sequences the serial shift-out, pulses the latch enable and returns a one-cycle acknowledge.
- Sits between the SoC peripheral registers and the board pins.

---
 rtl/p2s_share_ctrl.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/p2s_share_ctrl.sv
// Shares one serial shift chain between two parallel requesters. It grants them
// round-robin, shifts out the captured word, pulses the latch enable and acknowledges.
module p2s_share_ctrl #(
    parameter int DATA_BITS = 16,
    parameter int CNT_BITS  = 5,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [DATA_BITS-1:0] data0,
    input  logic                 req1,
    input  logic [DATA_BITS-1:0] data1,
    output logic [1:0]           gnt,
    output logic [1:0]           ack,
    output logic                 busy,
    output logic                 s_clk,
    output logic                 s_dout,
    output logic                 s_clrn,
    output logic                 s_pen
);

    localparam int DIV_BITS = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(CLK_DIV - 1);
    localparam logic [CNT_BITS-1:0] BIT_LAST = CNT_BITS'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    state_t               r_state, w_state;
    logic [1:0]           r_gnt, w_gnt;
    logic [1:0]           r_ack, w_ack;
    logic                 r_busy, w_busy;
    logic                 r_sclk, w_sclk;
    logic                 r_sdout, w_sdout;
    logic                 r_pen, w_pen;
    logic                 r_clrn;
    logic                 r_last_one, w_last_one;  // 1 = requester 1 was served last
    logic [DIV_BITS-1:0]  r_div, w_div;
    logic [CNT_BITS-1:0]  r_bit, w_bit;
    logic [DATA_BITS-1:0] r_sr, w_sr;

    logic                 w_pick_one;
    logic [DATA_BITS-1:0] w_load;
    logic [DATA_BITS-1:0] w_sr_shifted;

    // On a tie, serve whichever requester was not served last.
    assign w_pick_one   = req1 & (~req0 | ~r_last_one);
    assign w_load       = w_pick_one ? data1 : data0;
    assign w_sr_shifted = MSB_FIRST ? {r_sr[DATA_BITS-2:0], 1'b0}
                                    : {1'b0, r_sr[DATA_BITS-1:1]};

    always_comb begin
        // NOTE: every next-value signal gets a default first so that no path can infer a latch.
        w_state    = r_state;
        w_gnt      = r_gnt;
        w_ack      = r_ack;
        w_busy     = r_busy;
        w_sclk     = r_sclk;
        w_sdout    = r_sdout;
        w_pen      = r_pen;
        w_last_one = r_last_one;
        w_div      = r_div;
        w_bit      = r_bit;
        w_sr       = r_sr;

        unique case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_state    = S_SHIFT;
                    w_gnt      = w_pick_one ? 2'b10 : 2'b01;
                    w_busy     = 1'b1;
                    w_last_one = w_pick_one;
                    w_sr       = w_load;
                    w_sdout    = MSB_FIRST ? w_load[DATA_BITS-1] : w_load[0];
                    w_sclk     = 1'b0;
                    w_div      = '0;
                    w_bit      = '0;
                end
            end
            S_SHIFT: begin
                if (r_div == DIV_LAST) begin
                    w_div = '0;
                    if (!r_sclk) begin
                        w_sclk = 1'b1;
                    end else begin
                        // The falling boundary of s_clk is the only point where data advances.
                        w_sclk = 1'b0;
                        if (r_bit == BIT_LAST) begin
                            w_state = S_LATCH;
                            w_sdout = 1'b0;
                            w_pen   = 1'b1;
                        end else begin
                            w_bit   = r_bit + 1'b1;
                            w_sr    = w_sr_shifted;
                            w_sdout = MSB_FIRST ? w_sr_shifted[DATA_BITS-1] : w_sr_shifted[0];
                        end
                    end
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            S_LATCH: begin
                if (r_div == DIV_LAST) begin
                    w_div   = '0;
                    w_pen   = 1'b0;
                    w_ack   = r_gnt;
                    w_state = S_DONE;
                end else begin
                    w_div = r_div + 1'b1;
                end
            end
            S_DONE: begin
                w_ack   = 2'b00;
                w_gnt   = 2'b00;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_gnt      <= 2'b00;
            r_ack      <= 2'b00;
            r_busy     <= 1'b0;
            r_sclk     <= 1'b0;
            r_sdout    <= 1'b0;
            r_pen      <= 1'b0;
            r_clrn     <= 1'b0;
            r_last_one <= 1'b1;
            r_div      <= '0;
            r_bit      <= '0;
            r_sr       <= '0;
        end else begin
            r_state    <= w_state;
            r_gnt      <= w_gnt;
            r_ack      <= w_ack;
            r_busy     <= w_busy;
            r_sclk     <= w_sclk;
            r_sdout    <= w_sdout;
            r_pen      <= w_pen;
            r_clrn     <= 1'b1;
            r_last_one <= w_last_one;
            r_div      <= w_div;
            r_bit      <= w_bit;
            r_sr       <= w_sr;
        end
    end

    assign gnt    = r_gnt;
    assign ack    = r_ack;
    assign busy   = r_busy;
    assign s_clk  = r_sclk;
    assign s_dout = r_sdout;
    assign s_clrn = r_clrn;
    assign s_pen  = r_pen;

endmodule
